// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo_if
// Brief   : Producer-side word handshake into the FIFO-backed UART transmitter.
// Revision: 1.0
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;

  modport master (output i_Tx_DV, output i_Tx_Byte, input o_Tx_Ready);
  modport slave  (input i_Tx_DV, input i_Tx_Byte, output o_Tx_Ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : UART transmitter with input FIFO, optional parity, 1/2 stop bits.
// Revision: 1.0
// ============================================================================
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  wire logic                        i_Clock,
  input  wire logic                        i_rst,
  uart_tx_fifo_if.slave                    tx_if,
  output logic                             o_Tx_Serial,
  output logic                             o_Tx_Active,
  output logic                             o_Tx_Done,
  output logic                             o_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]      o_Fifo_Count
);

  localparam int                  c_AW      = $clog2(FIFO_DEPTH);
  localparam int                  c_CW      = $clog2(CLKS_PER_BIT);
  localparam logic [c_CW-1:0]     c_CNT_MAX = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_AW:0]       c_FULL    = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]          c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]          c_STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]      r_wr_ptr;
  logic [c_AW-1:0]      r_rd_ptr;
  logic [c_AW:0]        r_count;
  logic                 r_ready;
  logic                 r_overflow;

  // Serialiser state
  state_t               r_state;
  logic [c_CW-1:0]      r_clk_cnt;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_serial;
  logic                 r_active;
  logic                 r_done;

  state_t               w_state_next;
  logic [c_CW-1:0]      w_clk_cnt_next;
  logic [3:0]           w_bit_idx_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_parity_next;
  logic                 w_serial_next;
  logic                 w_pop;
  logic                 w_done;
  logic                 w_wr;
  logic                 w_bit_end;
  logic                 w_fifo_nempty;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_parity;
  logic [c_AW:0]        w_count_next;

  assign w_wr          = tx_if.i_Tx_DV & r_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];
  // Odd mode inverts the XOR so data plus parity carries an odd number of ones.
  assign w_head_parity = (PARITY_MODE == 1) ? ~(^w_head) : (^w_head);
  assign w_bit_end     = (r_clk_cnt == c_CNT_MAX);

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_wr && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= tx_if.i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count    <= w_count_next;
      r_ready    <= (w_count_next != c_FULL);
      r_overflow <= tx_if.i_Tx_DV & ~r_ready;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_pop          = 1'b0;
    w_done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_clk_cnt_next = '0;
        if (w_fifo_nempty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_head;
          w_parity_next = w_head_parity;
          w_state_next  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == c_DATA_LAST) begin
            w_bit_idx_next = '0;
            w_state_next   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_bit_idx_next = '0;
          w_state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_idx == c_STOP_LAST) begin
            w_done         = 1'b1;
            w_bit_idx_next = '0;
            // Chain straight into the next start bit so frames stay gap-free.
            if (w_fifo_nempty) begin
              w_pop         = 1'b1;
              w_shift_next  = w_head;
              w_parity_next = w_head_parity;
              w_state_next  = S_START;
            end else begin
              w_state_next  = S_IDLE;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_clk_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    w_serial_next = 1'b1;
    unique case (w_state_next)
      S_START:  w_serial_next = 1'b0;
      S_DATA:   w_serial_next = w_shift_next[0];
      S_PARITY: w_serial_next = w_parity_next;
      default:  w_serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_serial  <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_serial  <= w_serial_next;
      r_active  <= (w_state_next != S_IDLE);
      r_done    <= w_done;
    end
  end

  assign tx_if.o_Tx_Ready = r_ready;
  assign o_Tx_Serial      = r_serial;
  assign o_Tx_Active      = r_active;
  assign o_Tx_Done        = r_done;
  assign o_Overflow       = r_overflow;
  assign o_Fifo_Count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Directed bench for uart_tx_fifo across four frame configurations.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv  = 1'b0;
  logic [8:0] byte_v = '0;
  int         sel = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  // 0: 8N1 depth16, 1: 8E1, 2: 8O2 depth4, 3: 7E1
  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_d ();

  logic       ser_m  [4];
  logic       act_m  [4];
  logic       done_m [4];
  logic       ovf_m  [4];
  logic       rdy_m  [4];
  logic [4:0] cnt_m  [4];
  logic [4:0] cnt_a, cnt_b, cnt_d;
  logic [2:0] cnt_c;

  assign if_a.i_Tx_DV = dv && (sel == 0);
  assign if_b.i_Tx_DV = dv && (sel == 1);
  assign if_c.i_Tx_DV = dv && (sel == 2);
  assign if_d.i_Tx_DV = dv && (sel == 3);
  assign if_a.i_Tx_Byte = byte_v[7:0];
  assign if_b.i_Tx_Byte = byte_v[7:0];
  assign if_c.i_Tx_Byte = byte_v[7:0];
  assign if_d.i_Tx_Byte = byte_v[6:0];
  assign rdy_m[0] = if_a.o_Tx_Ready;
  assign rdy_m[1] = if_b.o_Tx_Ready;
  assign rdy_m[2] = if_c.o_Tx_Ready;
  assign rdy_m[3] = if_d.o_Tx_Ready;
  assign cnt_m[0] = cnt_a;
  assign cnt_m[1] = cnt_b;
  assign cnt_m[2] = {2'b00, cnt_c};
  assign cnt_m[3] = cnt_d;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .i_Clock(clk), .i_rst(rst), .tx_if(if_a), .o_Tx_Serial(ser_m[0]), .o_Tx_Active(act_m[0]),
    .o_Tx_Done(done_m[0]), .o_Overflow(ovf_m[0]), .o_Fifo_Count(cnt_a));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
    .i_Clock(clk), .i_rst(rst), .tx_if(if_b), .o_Tx_Serial(ser_m[1]), .o_Tx_Active(act_m[1]),
    .o_Tx_Done(done_m[1]), .o_Overflow(ovf_m[1]), .o_Fifo_Count(cnt_b));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_Clock(clk), .i_rst(rst), .tx_if(if_c), .o_Tx_Serial(ser_m[2]), .o_Tx_Active(act_m[2]),
    .o_Tx_Done(done_m[2]), .o_Overflow(ovf_m[2]), .o_Fifo_Count(cnt_c));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_d (
    .i_Clock(clk), .i_rst(rst), .tx_if(if_d), .o_Tx_Serial(ser_m[3]), .o_Tx_Active(act_m[3]),
    .o_Tx_Done(done_m[3]), .o_Overflow(ovf_m[3]), .o_Fifo_Count(cnt_d));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [8:0] b);
    dv     = 1'b1;
    byte_v = b;
    tick();
    dv     = 1'b0;
  endtask

  // bits[n] is the n-th line bit of the frame, start bit first; 4 clocks per bit.
  task automatic check_frame(input string tag, input int nbits, input logic [11:0] bits, input int skip);
    for (int i = skip; i < nbits * 4; i++) begin
      check_eq({tag, ".line"}, 32'(ser_m[sel]), 32'(bits[i / 4]));
      check_eq({tag, ".active"}, 32'(act_m[sel]), 32'd1);
      check_eq({tag, ".done"}, 32'(done_m[sel]), 32'd0);
      tick();
    end
  endtask

  task automatic check_frame_end(input string tag, input logic more);
    check_eq({tag, ".done_pulse"}, 32'(done_m[sel]), 32'd1);
    check_eq({tag, ".active_after"}, 32'(act_m[sel]), 32'(more));
    check_eq({tag, ".line_after"}, 32'(ser_m[sel]), 32'(!more));
  endtask

  logic [11:0] ovf_frames [5];
  int          exp_cnt   [6];
  int          exp_rdy   [6];

  initial begin
    ovf_frames = '{12'hC02, 12'hC04, 12'hE06, 12'hC08, 12'hE0A};
    exp_cnt    = '{1, 1, 2, 3, 4, 4};
    exp_rdy    = '{1, 1, 1, 1, 0, 0};

    tick();
    tick();
    for (int s = 0; s < 4; s += 2) begin
      sel = s;
      check_eq("rst.serial", 32'(ser_m[sel]), 32'd1);
      check_eq("rst.active", 32'(act_m[sel]), 32'd0);
      check_eq("rst.done", 32'(done_m[sel]), 32'd0);
      check_eq("rst.overflow", 32'(ovf_m[sel]), 32'd0);
      check_eq("rst.count", 32'(cnt_m[sel]), 32'd0);
      check_eq("rst.ready", 32'(rdy_m[sel]), 32'd1);
    end
    rst = 1'b0;
    tick();

    // 8N1 0xA5: idle one cycle after the write edge, start bit from the next one
    sel = 0;
    write_word(9'h0A5);
    check_eq("a5.line_k", 32'(ser_m[sel]), 32'd1);
    check_eq("a5.count_k", 32'(cnt_m[sel]), 32'd1);
    tick();
    check_frame("a5", 10, 12'h34A, 0);
    check_frame_end("a5", 1'b0);
    check_eq("a5.count_end", 32'(cnt_m[sel]), 32'd0);
    tick();
    check_eq("a5.done_once", 32'(done_m[sel]), 32'd0);

    sel = 1;
    write_word(9'h007);
    tick();
    check_frame("even07", 11, 12'h60E, 0);
    check_frame_end("even07", 1'b0);
    tick();

    sel = 2;
    write_word(9'h007);
    tick();
    check_frame("odd07", 12, 12'hC0E, 0);
    check_frame_end("odd07", 1'b0);
    tick();

    sel = 3;
    write_word(9'h07F);
    tick();
    check_frame("d7even", 10, 12'h3FE, 0);
    check_frame_end("d7even", 1'b0);
    tick();

    // Three back-to-back words; the first pops on the second write edge
    sel = 0;
    dv = 1'b1;
    byte_v = 9'h011;
    tick();
    check_eq("b2b.count1", 32'(cnt_m[sel]), 32'd1);
    byte_v = 9'h022;
    tick();
    check_eq("b2b.count2", 32'(cnt_m[sel]), 32'd1);
    check_eq("b2b.start", 32'(ser_m[sel]), 32'd0);
    byte_v = 9'h033;
    tick();
    dv = 1'b0;
    check_eq("b2b.count3", 32'(cnt_m[sel]), 32'd2);
    check_frame("b2b.f1", 10, 12'h222, 1);
    check_frame_end("b2b.f1", 1'b1);
    check_eq("b2b.count_f2", 32'(cnt_m[sel]), 32'd1);
    tick();
    check_frame("b2b.f2", 10, 12'h244, 1);
    check_frame_end("b2b.f2", 1'b1);
    check_eq("b2b.count_f3", 32'(cnt_m[sel]), 32'd0);
    tick();
    check_frame("b2b.f3", 10, 12'h266, 1);
    check_frame_end("b2b.f3", 1'b0);
    tick();

    // Depth-4 FIFO, six writes: sixth is dropped and flagged
    sel = 2;
    dv = 1'b1;
    for (int w = 0; w < 6; w++) begin
      byte_v = 9'(w + 1);
      tick();
      check_eq("ovf.count", 32'(cnt_m[sel]), 32'(exp_cnt[w]));
      check_eq("ovf.ready", 32'(rdy_m[sel]), 32'(exp_rdy[w]));
      check_eq("ovf.pulse", 32'(ovf_m[sel]), 32'(w == 5));
    end
    dv = 1'b0;
    tick();
    check_eq("ovf.pulse_end", 32'(ovf_m[sel]), 32'd0);
    for (int f = 0; f < 5; f++) begin
      check_frame("ovf.frame", 12, ovf_frames[f], (f == 0) ? 5 : 1);
      check_frame_end("ovf.frame", f < 4);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      check_eq("ovf.idle_line", 32'(ser_m[sel]), 32'd1);
      check_eq("ovf.idle_count", 32'(cnt_m[sel]), 32'd0);
      tick();
    end

    // Reset in the middle of data bit 3 with two words queued
    sel = 0;
    dv = 1'b1;
    byte_v = 9'h055;
    tick();
    byte_v = 9'h066;
    tick();
    byte_v = 9'h077;
    tick();
    dv = 1'b0;
    check_eq("rstmid.queued", 32'(cnt_m[sel]), 32'd2);
    repeat (16) tick();
    check_eq("rstmid.bit3", 32'(ser_m[sel]), 32'd0);
    check_eq("rstmid.active", 32'(act_m[sel]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstmid.line", 32'(ser_m[sel]), 32'd1);
    check_eq("rstmid.count", 32'(cnt_m[sel]), 32'd0);
    check_eq("rstmid.active_low", 32'(act_m[sel]), 32'd0);
    check_eq("rstmid.ready", 32'(rdy_m[sel]), 32'd1);
    check_eq("rstmid.done", 32'(done_m[sel]), 32'd0);
    for (int i = 0; i < 60; i++) begin
      tick();
      check_eq("rstmid.hold_line", 32'(ser_m[sel]), 32'd1);
      check_eq("rstmid.no_done", 32'(done_m[sel]), 32'd0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
